// File: rtl/sd4_align_accumulator.sv
// SD4 align/accumulate stage: aligns signed-magnitude products to a running
// max exponent and sums N_TERMS of them. Optional rounding: SD4_ALIGN_ROUND_EN.
module sd4_align_accumulator #(
  parameter int N_TERMS   = 4,
  parameter int ALIGN_POS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [10:0] in_mant,
  input  logic [5:0]  in_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] signed_sum,
  output logic [5:0]  exp_max
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  localparam logic [3:0] LAST = 4'(N_TERMS - 1);

  state_t             state_q, state_d;
  logic signed [19:0] acc_q, acc_d;
  logic [5:0]         acc_exp_q, acc_exp_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               acc_empty_q, acc_empty_d;
  logic               out_valid_q, out_valid_d;
  logic [19:0]        sum_q, sum_d;
  logic [5:0]         exp_max_q, exp_max_d;

  logic [19:0]        a_op;
  logic signed [6:0]  ediff;
  logic               exp_up;
  logic [6:0]         dp;
  logic [4:0]         sa;
  logic [19:0]        a_sh;
  logic signed [19:0] acc_sh;
  logic [19:0]        a_neg;
  logic [19:0]        term;
  logic signed [19:0] acc_new;
  logic               accept;
  logic               out_hs;

  assign a_op   = 20'(in_mant) << ALIGN_POS;
  assign ediff  = {in_exp[5], in_exp} - {acc_exp_q[5], acc_exp_q};
  assign exp_up = !ediff[6] && (ediff != 7'sd0);
  assign dp     = 7'(-ediff);
  assign sa     = (ediff > 7'sd19) ? 5'd19 : ediff[4:0];

  assign in_ready = (state_q != OUT) && !flush;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

`ifdef SD4_ALIGN_ROUND_EN
  logic [19:0]        a_pre;
  logic signed [19:0] acc_pre;
`endif

  // Align the product (down) or the accumulator (up) to the larger exponent
  always_comb begin
    a_sh   = a_op;
    acc_sh = acc_q;
`ifdef SD4_ALIGN_ROUND_EN
    a_pre   = '0;
    acc_pre = '0;
`endif
    if (exp_up) begin
`ifdef SD4_ALIGN_ROUND_EN
      acc_pre = acc_q >>> (sa - 5'd1);
      acc_sh  = (acc_pre >>> 1) + 20'sd0 + {19'd0, acc_pre[0]};
`else
      acc_sh = acc_q >>> sa;
`endif
    end else if (dp >= 7'd16) begin
      a_sh = '0;
    end else if (dp != 7'd0) begin
`ifdef SD4_ALIGN_ROUND_EN
      a_pre = a_op >> (dp - 7'd1);
      a_sh  = (a_pre >> 1) + {19'd0, a_pre[0]};
`else
      a_sh = a_op >> dp;
`endif
    end
  end

  // Signed contribution and new accumulator value for an accepted product
  always_comb begin
    a_neg = -a_op;
    term  = in_sign ? -a_sh : a_sh;
    if (acc_empty_q) begin
      acc_new = in_sign ? a_neg : a_op;
    end else if (exp_up) begin
      acc_new = acc_sh + (in_sign ? a_neg : a_op);
    end else begin
      acc_new = acc_q + term;
    end
  end

  // Next-state: flush first, then output handshake, then product acceptance
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_exp_d   = acc_exp_q;
    cnt_d       = cnt_q;
    acc_empty_d = acc_empty_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    exp_max_d   = exp_max_q;
    if (flush) begin
      state_d     = IDLE;
      acc_d       = '0;
      acc_exp_d   = '0;
      cnt_d       = '0;
      acc_empty_d = 1'b1;
      out_valid_d = 1'b0;
      sum_d       = '0;
      exp_max_d   = '0;
    end else if (state_q == OUT) begin
      if (out_hs) begin
        state_d     = IDLE;
        acc_d       = '0;
        acc_exp_d   = '0;
        cnt_d       = '0;
        acc_empty_d = 1'b1;
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (in_mant != 11'd0) begin
        acc_d       = acc_new;
        acc_exp_d   = acc_empty_q ? in_exp
                    : (exp_up ? in_exp : acc_exp_q);
        acc_empty_d = 1'b0;
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST) begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        sum_d       = acc_d;
        exp_max_d   = acc_exp_d;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_exp_q   <= '0;
      cnt_q       <= '0;
      acc_empty_q <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      exp_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_exp_q   <= acc_exp_d;
      cnt_q       <= cnt_d;
      acc_empty_q <= acc_empty_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      exp_max_q   <= exp_max_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign signed_sum = sum_q;
  assign exp_max    = exp_max_q;

endmodule

// File: tb/tb_sd4_align_accumulator.sv
// Directed bench for sd4_align_accumulator (N_TERMS=4).
// Honours SD4_ALIGN_ROUND_EN for the rounding vector.
module tb_sd4_align_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [10:0] in_mant;
  logic [5:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] signed_sum;
  logic [5:0]  exp_max;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sd4_align_accumulator #(
    .N_TERMS  (4),
    .ALIGN_POS(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .signed_sum(signed_sum),
    .exp_max   (exp_max)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] p(input logic s,
                                    input logic [10:0] m,
                                    input logic [5:0] e);
    return {s, m, e};
  endfunction

  task automatic send(input logic [17:0] v);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    {in_sign, in_mant, in_exp} = v;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("hs_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_ovd_clr"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ird_set"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic grp(input string tag,
                     input logic [17:0] p0, p1, p2, p3,
                     input logic [19:0] es,
                     input logic [5:0] ee,
                     input bit do_take);
    send(p0);
    send(p1);
    send(p2);
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    send(p3);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_ird"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_sum"}, {12'd0, signed_sum}, {12'd0, es});
    chk({tag, "_exp"}, {26'd0, exp_max}, {26'd0, ee});
    if (do_take) take(tag);
  endtask

  logic [17:0] z;
  logic [17:0] e3;
  logic [19:0] rnd_sum;

  initial begin
    z  = p(1'b0, 11'd0, 6'd0);
    e3 = p(1'b0, 11'h400, 6'd3);
`ifdef SD4_ALIGN_ROUND_EN
    rnd_sum = 20'h08221;
`else
    rnd_sum = 20'h08220;
`endif
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_ovd", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {12'd0, signed_sum}, 32'd0);
    chk("rst_exp", {26'd0, exp_max}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ird", {31'd0, in_ready}, 32'd1);

    grp("same", e3, e3, e3, e3, 20'h20000, 6'd3, 1'b1);
    grp("desc", p(1'b0, 11'h400, 6'd5), p(1'b1, 11'h400, 6'd3),
        z, z, 20'h06000, 6'd5, 1'b1);
    grp("asc", p(1'b0, 11'h400, 6'd0), p(1'b0, 11'h400, 6'd2),
        z, z, 20'h0A000, 6'd2, 1'b1);
    grp("wrap", p(1'b0, 11'h400, 6'h1F), p(1'b0, 11'h7FF, 6'h20),
        z, z, 20'h08000, 6'h1F, 1'b1);
    grp("neg", p(1'b1, 11'h400, 6'd3), z, z, z,
        20'hF8000, 6'd3, 1'b1);
    grp("zero", z, p(1'b1, 11'd0, 6'd9), z, z,
        20'h00000, 6'd0, 1'b1);
    grp("rnd", p(1'b0, 11'h401, 6'd6), p(1'b0, 11'h401, 6'd0),
        z, z, rnd_sum, 6'd6, 1'b1);

    grp("bp", e3, e3, e3, e3, 20'h20000, 6'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    {in_sign, in_mant, in_exp} = p(1'b0, 11'h7FF, 6'd10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ovd", {31'd0, out_valid}, 32'd1);
      chk("bp_ird", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {12'd0, signed_sum}, 32'h20000);
      chk("bp_exp", {26'd0, exp_max}, 32'd3);
    end
    take("bp");

    send(e3);
    send(e3);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    {in_sign, in_mant, in_exp} = e3;
    #1;
    chk("fl_ird", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_ovd", {31'd0, out_valid}, 32'd0);
    grp("post_fl", e3, e3, e3, e3, 20'h20000, 6'd3, 1'b1);

    send(e3);
    send(e3);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_ovd", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    grp("post_rmid", p(1'b0, 11'h400, 6'd5), p(1'b1, 11'h400, 6'd3),
        z, z, 20'h06000, 6'd5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rout_ovd", {31'd0, out_valid}, 32'd0);
    chk("rout_sum", {12'd0, signed_sum}, 32'd0);
    chk("rout_exp", {26'd0, exp_max}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    grp("post_rout", e3, e3, e3, e3, 20'h20000, 6'd3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
